sirv_spi_slave_port: RTL and testbench

- Single-lane SPI responder: samples external SCK/CS/MOSI pins through synchronizers, shifts received frames into a word and shifts a host-supplied word out on MISO.
- Sits between the pad-level pin bundle (ival/oval/oe/ie/pue/ds per pin) and a peripheral-side byte interface. It is the slave-side counterpart of the SPI master pin port.
- All logic runs on the system clock; SCK is oversampled, never used as a clock.

---
 rtl/sirv_spi_slave_port.sv | 261 ++++++++++++++++++++++++++
 tb/tb_sirv_spi_slave_port.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sirv_spi_slave_port.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// sirv_spi_slave_port
//
// Single-lane SPI responder. SCK, CS and MOSI are oversampled on the system
// clock through synchronizer chains. Received frames are shifted into a word
// and delivered as a one-cycle pulse. A host-supplied word (one-entry holding
// buffer) is shifted out on MISO. If no word is waiting at a reload, an
// all-ones fill word is sent and an underrun pulse is raised.
//
// Optional feature: define SIRV_SPI_SLAVE_ENDIAN_EN to add io_cfg_lsb_first
// (LSB-first shifting on both directions, latched at CS assertion).
//
// Ports:
//   clock, reset_n                 system clock, synchronous active-low reset
//   io_cfg_cpol / io_cfg_cpha      SPI mode select
//   io_cfg_lsb_first               (optional) LSB-first bit order
//   io_pins_*_i_ival               raw SCK / CS / MOSI pins
//   io_pins_dq_1_o_oval / _o_oe    MISO value and output enable
//   io_pins_*_o_{ie,pue,ds}        constant pad attributes
//   io_tx_valid/_data/_ready       host word offer (valid/ready)
//   io_rx_valid/_data              received word, one-cycle pulse
//   io_tx_underrun                 fill word loaded, one-cycle pulse
//   io_active                      synchronized CS asserted
//
// Handshake: a tx word is accepted on a clock edge where io_tx_valid and
// io_tx_ready are both high; io_rx_valid has no back-pressure.
// -----------------------------------------------------------------------------
module sirv_spi_slave_port #(
   parameter int DATA_W      = 8,
   parameter int SYNC_STAGES = 3
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              io_cfg_cpol,
   input  logic              io_cfg_cpha,
`ifdef SIRV_SPI_SLAVE_ENDIAN_EN
   input  logic              io_cfg_lsb_first,
`endif
   input  logic              io_pins_sck_i_ival,
   input  logic              io_pins_cs_0_i_ival,
   input  logic              io_pins_dq_0_i_ival,
   output logic              io_pins_dq_1_o_oval,
   output logic              io_pins_dq_1_o_oe,
   output logic              io_pins_sck_o_ie,
   output logic              io_pins_sck_o_pue,
   output logic              io_pins_sck_o_ds,
   output logic              io_pins_cs_0_o_ie,
   output logic              io_pins_cs_0_o_pue,
   output logic              io_pins_cs_0_o_ds,
   output logic              io_pins_dq_0_o_ie,
   output logic              io_pins_dq_0_o_pue,
   output logic              io_pins_dq_0_o_ds,
   output logic              io_pins_dq_1_o_ie,
   output logic              io_pins_dq_1_o_pue,
   output logic              io_pins_dq_1_o_ds,
   input  logic              io_tx_valid,
   input  logic [DATA_W-1:0] io_tx_data,
   output logic              io_tx_ready,
   output logic              io_rx_valid,
   output logic [DATA_W-1:0] io_rx_data,
   output logic              io_tx_underrun,
   output logic              io_active
);

   localparam int CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ACTIVE = 1'b1
   } state_e;

   // ---------------------------------------------------------------------
   // Input synchronizers plus one extra flop for edge detection
   // ---------------------------------------------------------------------
   logic [SYNC_STAGES-1:0] sck_sync_q;
   logic [SYNC_STAGES-1:0] cs_sync_q;
   logic [SYNC_STAGES-1:0] mosi_sync_q;
   logic                   sck_prev_q;
   logic                   cs_prev_q;

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         sck_sync_q  <= '0;
         cs_sync_q   <= '1;
         mosi_sync_q <= '0;
         sck_prev_q  <= 1'b0;
         cs_prev_q   <= 1'b1;
      end else begin
         sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], io_pins_sck_i_ival};
         cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], io_pins_cs_0_i_ival};
         mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], io_pins_dq_0_i_ival};
         sck_prev_q  <= sck_sync_q[SYNC_STAGES-1];
         cs_prev_q   <= cs_sync_q[SYNC_STAGES-1];
      end
   end

   logic sck_s, cs_s, mosi_s;
   assign sck_s  = sck_sync_q[SYNC_STAGES-1];
   assign cs_s   = cs_sync_q[SYNC_STAGES-1];
   assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

   logic sck_rise, sck_fall, cs_fall, cs_rise;
   assign sck_rise = sck_s & ~sck_prev_q;
   assign sck_fall = ~sck_s & sck_prev_q;
   assign cs_fall  = ~cs_s & cs_prev_q;
   assign cs_rise  = cs_s & ~cs_prev_q;

   // ---------------------------------------------------------------------
   // Registered state
   // ---------------------------------------------------------------------
   state_e              state_q;
   logic [CNT_W-1:0]    bit_cnt_q;
   logic [DATA_W-1:0]   rx_shift_q;
   logic [DATA_W-1:0]   shift_out_q;
   logic [DATA_W-1:0]   hold_q;
   logic                tx_full_q;
   logic [DATA_W-1:0]   rx_data_q;
   logic                rx_valid_q;
   logic                underrun_q;
   logic                lsb_q;

   // ---------------------------------------------------------------------
   // Edge qualification and reload decision
   // ---------------------------------------------------------------------
   logic mode;
   logic in_frame;
   logic sample_edge;
   logic shift_edge;
   logic last_bit;
   logic reload;
   logic tx_accept;
   logic lsb_cfg;

`ifdef SIRV_SPI_SLAVE_ENDIAN_EN
   assign lsb_cfg = io_cfg_lsb_first;
`else
   assign lsb_cfg = 1'b0;
`endif

   // Modes 0 and 3 sample on the rising SCK edge, modes 1 and 2 on the
   // falling edge. A CS release in the same cycle as an SCK edge wins.
   assign mode        = io_cfg_cpol ^ io_cfg_cpha;
   assign in_frame    = (state_q == ST_ACTIVE) & ~cs_rise;
   assign sample_edge = in_frame & (mode ? sck_fall : sck_rise);
   assign shift_edge  = in_frame & (mode ? sck_rise : sck_fall);
   assign last_bit    = (bit_cnt_q == CNT_LAST);
   assign reload      = ((state_q == ST_IDLE) & cs_fall) | (sample_edge & last_bit);
   assign tx_accept   = io_tx_valid & ~tx_full_q;

   logic [DATA_W-1:0] rx_shift_d;
   logic [DATA_W-1:0] shift_out_d;
   assign rx_shift_d  = lsb_q ? {mosi_s, rx_shift_q[DATA_W-1:1]}
                              : {rx_shift_q[DATA_W-2:0], mosi_s};
   assign shift_out_d = lsb_q ? {1'b0, shift_out_q[DATA_W-1:1]}
                              : {shift_out_q[DATA_W-2:0], 1'b0};

   // ---------------------------------------------------------------------
   // FSM and datapath
   // ---------------------------------------------------------------------
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         bit_cnt_q   <= '0;
         rx_shift_q  <= '0;
         shift_out_q <= '0;
         hold_q      <= '0;
         tx_full_q   <= 1'b0;
         rx_data_q   <= '0;
         rx_valid_q  <= 1'b0;
         underrun_q  <= 1'b0;
`ifdef SIRV_SPI_SLAVE_ENDIAN_EN
         lsb_q       <= 1'b0;
`endif
      end else begin
         rx_valid_q <= 1'b0;
         underrun_q <= 1'b0;

         // Holding buffer fill; never collides with a reload drain because
         // acceptance needs the buffer empty.
         if (tx_accept) begin
            hold_q    <= io_tx_data;
            tx_full_q <= 1'b1;
         end

         case (state_q)
            ST_IDLE: begin
               if (cs_fall) begin
                  state_q   <= ST_ACTIVE;
                  bit_cnt_q <= '0;
`ifdef SIRV_SPI_SLAVE_ENDIAN_EN
                  lsb_q     <= lsb_cfg;
`endif
               end
            end
            ST_ACTIVE: begin
               if (cs_rise) begin
                  // Abandon any partial frame silently.
                  state_q    <= ST_IDLE;
                  bit_cnt_q  <= '0;
                  rx_shift_q <= '0;
               end else if (sample_edge) begin
                  rx_shift_q <= rx_shift_d;
                  if (last_bit) begin
                     bit_cnt_q  <= '0;
                     rx_data_q  <= rx_shift_d;
                     rx_valid_q <= 1'b1;
                  end else begin
                     bit_cnt_q <= bit_cnt_q + 1'b1;
                  end
               end
            end
            default: state_q <= ST_IDLE;
         endcase

         // The shift is suppressed while bit_cnt is 0 so the freshly
         // reloaded first bit stays on MISO for both CPHA settings.
         if (reload) begin
            if (tx_full_q) begin
               shift_out_q <= hold_q;
               tx_full_q   <= 1'b0;
            end else begin
               shift_out_q <= '1;
               underrun_q  <= 1'b1;
            end
         end else if (shift_edge && (bit_cnt_q != '0)) begin
            shift_out_q <= shift_out_d;
         end
      end
   end

`ifndef SIRV_SPI_SLAVE_ENDIAN_EN
   assign lsb_q = lsb_cfg;
`endif

   // ---------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------
   assign io_active           = (state_q == ST_ACTIVE);
   assign io_pins_dq_1_o_oval = lsb_q ? shift_out_q[0] : shift_out_q[DATA_W-1];
   assign io_pins_dq_1_o_oe   = io_active;
   assign io_tx_ready         = ~tx_full_q;
   assign io_rx_valid         = rx_valid_q;
   assign io_rx_data          = rx_data_q;
   assign io_tx_underrun      = underrun_q;

   assign io_pins_sck_o_ie    = 1'b1;
   assign io_pins_sck_o_pue   = 1'b0;
   assign io_pins_sck_o_ds    = 1'b0;
   assign io_pins_cs_0_o_ie   = 1'b1;
   assign io_pins_cs_0_o_pue  = 1'b1;
   assign io_pins_cs_0_o_ds   = 1'b0;
   assign io_pins_dq_0_o_ie   = 1'b1;
   assign io_pins_dq_0_o_pue  = 1'b0;
   assign io_pins_dq_0_o_ds   = 1'b0;
   assign io_pins_dq_1_o_ie   = 1'b0;
   assign io_pins_dq_1_o_pue  = 1'b0;
   assign io_pins_dq_1_o_ds   = 1'b1;

endmodule

// File: tb/tb_sirv_spi_slave_port.sv
`timescale 1ns/1ps
// Directed bench for sirv_spi_slave_port: acts as SPI master on the pins and
// as host on the tx/rx side. Pins are driven on the falling system-clock edge
// and DUT outputs are sampled there too.
module tb_sirv_spi_slave_port;

  localparam int HALF = 8;  // SCK half period in system clocks

  logic clock = 1'b0;
  logic reset_n;
  logic cpol, cpha;
  logic lsb_first;
  logic sck, cs, mosi;
  logic miso, miso_oe;
  logic sck_ie, sck_pue, sck_ds, cs_ie, cs_pue, cs_ds;
  logic dq0_ie, dq0_pue, dq0_ds, dq1_ie, dq1_pue, dq1_ds;
  logic tx_valid;
  logic [7:0] tx_data;
  logic tx_ready, rx_valid, tx_underrun, active;
  logic [7:0] rx_data;

  int total = 0;
  int bad = 0;
  int rx_cnt = 0;
  int un_cnt = 0;
  int rx_base, un_base;
  logic [7:0] rx_words[$];
  logic [7:0] got;

  always #5 clock = ~clock;

  sirv_spi_slave_port #(.DATA_W(8), .SYNC_STAGES(3)) dut (
    .clock               (clock),
    .reset_n             (reset_n),
    .io_cfg_cpol         (cpol),
    .io_cfg_cpha         (cpha),
`ifdef SIRV_SPI_SLAVE_ENDIAN_EN
    .io_cfg_lsb_first    (lsb_first),
`endif
    .io_pins_sck_i_ival  (sck),
    .io_pins_cs_0_i_ival (cs),
    .io_pins_dq_0_i_ival (mosi),
    .io_pins_dq_1_o_oval (miso),
    .io_pins_dq_1_o_oe   (miso_oe),
    .io_pins_sck_o_ie    (sck_ie),
    .io_pins_sck_o_pue   (sck_pue),
    .io_pins_sck_o_ds    (sck_ds),
    .io_pins_cs_0_o_ie   (cs_ie),
    .io_pins_cs_0_o_pue  (cs_pue),
    .io_pins_cs_0_o_ds   (cs_ds),
    .io_pins_dq_0_o_ie   (dq0_ie),
    .io_pins_dq_0_o_pue  (dq0_pue),
    .io_pins_dq_0_o_ds   (dq0_ds),
    .io_pins_dq_1_o_ie   (dq1_ie),
    .io_pins_dq_1_o_pue  (dq1_pue),
    .io_pins_dq_1_o_ds   (dq1_ds),
    .io_tx_valid         (tx_valid),
    .io_tx_data          (tx_data),
    .io_tx_ready         (tx_ready),
    .io_rx_valid         (rx_valid),
    .io_rx_data          (rx_data),
    .io_tx_underrun      (tx_underrun),
    .io_active           (active)
  );

  // Pulse monitor: a pulse longer than one cycle is counted more than once.
  always @(negedge clock) begin
    if (reset_n === 1'b1) begin
      if (rx_valid === 1'b1) begin
        rx_cnt++;
        rx_words.push_back(rx_data);
      end
      if (tx_underrun === 1'b1) un_cnt++;
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_tx(input logic [7:0] d);
    int n = 0;
    tx_valid = 1'b1;
    tx_data  = d;
    while (tx_ready !== 1'b1 && n < 64) begin
      wait_clk(1);
      n++;
    end
    check("tx_accept_timeout", 32'(n < 64), 32'd1);
    wait_clk(1);
    tx_valid = 1'b0;
  endtask

  task automatic cs_assert();
    cs = 1'b0;
    wait_clk(HALF);
  endtask

  task automatic cs_release();
    wait_clk(4);
    cs = 1'b1;
    wait_clk(HALF);
  endtask

  // Master side: shifts nbits of mosi_w and captures MISO at each sample edge.
  task automatic spi_xfer(input int nbits, input logic [7:0] mosi_w, input bit lsb,
                          output logic [7:0] miso_w);
    int idx;
    miso_w = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      idx = lsb ? i : 7 - i;
      if (cpha == 1'b0) begin
        mosi = mosi_w[idx];
        wait_clk(HALF);
        miso_w[idx] = miso;
        sck = ~cpol;
        wait_clk(HALF);
        sck = cpol;
      end else begin
        sck  = ~cpol;
        mosi = mosi_w[idx];
        wait_clk(HALF);
        miso_w[idx] = miso;
        sck = cpol;
        wait_clk(HALF);
      end
    end
  endtask

  initial begin
    reset_n = 1'b0; cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0;
    sck = 1'b0; cs = 1'b1; mosi = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
    wait_clk(4);
    reset_n = 1'b1;
    wait_clk(1);

    // Reset values and pad constants
    check("rst_tx_ready", tx_ready, 1);
    check("rst_active", active, 0);
    check("rst_miso_oe", miso_oe, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_underrun", tx_underrun, 0);
    check("pad_in_attrs", {sck_ie, sck_pue, sck_ds, cs_ie, cs_pue, cs_ds, dq0_ie, dq0_pue, dq0_ds},
          9'b100_110_100);
    check("pad_dq1_attrs", {dq1_ie, dq1_pue, dq1_ds}, 3'b001);

    // Mode 0: tx 0xA5, rx 0x3C
    rx_base = rx_cnt; un_base = un_cnt;
    push_tx(8'hA5);
    check("m0_ready_full", tx_ready, 0);
    cs_assert();
    check("m0_ready_after_cs", tx_ready, 1);
    check("m0_active", active, 1);
    check("m0_miso_oe", miso_oe, 1);
    check("m0_no_underrun_at_cs", un_cnt - un_base, 0);
    spi_xfer(8, 8'h3C, 1'b0, got);
    check("m0_miso_word", got, 8'hA5);
    wait_clk(6);
    check("m0_rx_pulses", rx_cnt - rx_base, 1);
    check("m0_rx_data", rx_data, 8'h3C);
    check("m0_end_reload_underrun", un_cnt - un_base, 1);
    cs_release();
    check("m0_inactive", active, 0);

    // Mode 3, two back-to-back words
    cpol = 1'b1; cpha = 1'b1; sck = 1'b1;
    wait_clk(HALF);
    rx_base = rx_cnt; un_base = un_cnt;
    push_tx(8'h81);
    cs_assert();
    push_tx(8'h7E);
    check("m3_ready_queued", tx_ready, 0);
    spi_xfer(8, 8'h12, 1'b0, got);
    check("m3_miso_w0", got, 8'h81);
    wait_clk(2);
    check("m3_no_underrun_w0", un_cnt - un_base, 0);
    check("m3_ready_after_w0", tx_ready, 1);
    spi_xfer(8, 8'h34, 1'b0, got);
    check("m3_miso_w1", got, 8'h7E);
    cs_release();
    check("m3_rx_pulses", rx_cnt - rx_base, 2);
    check("m3_rx_w0", rx_words[rx_base], 8'h12);
    check("m3_rx_w1", rx_words[rx_base + 1], 8'h34);
    check("m3_trailing_underrun", un_cnt - un_base, 1);

    // Mode 0, nothing queued: fill word
    cpol = 1'b0; cpha = 1'b0; sck = 1'b0;
    wait_clk(HALF);
    un_base = un_cnt;
    cs_assert();
    check("un_pulse_at_cs", un_cnt - un_base, 1);
    spi_xfer(8, 8'hC3, 1'b0, got);
    check("un_miso_fill", got, 8'hFF);
    cs_release();
    check("un_rx_data", rx_data, 8'hC3);

    // Aborted frame then a clean frame
    rx_base = rx_cnt;
    cs_assert();
    spi_xfer(5, 8'hF0, 1'b0, got);
    cs_release();
    check("abort_no_rx", rx_cnt - rx_base, 0);
    check("abort_rx_data_kept", rx_data, 8'hC3);
    cs_assert();
    spi_xfer(8, 8'h55, 1'b0, got);
    cs_release();
    check("after_abort_rx_cnt", rx_cnt - rx_base, 1);
    check("after_abort_rx_data", rx_data, 8'h55);

    // Reset mid-frame with the holding buffer full
    cs_assert();
    push_tx(8'h11);
    check("mid_ready_full", tx_ready, 0);
    spi_xfer(3, 8'hE0, 1'b0, got);
    reset_n = 1'b0;
    wait_clk(1);
    check("mid_rst_tx_ready", tx_ready, 1);
    check("mid_rst_active", active, 0);
    check("mid_rst_miso_oe", miso_oe, 0);
    check("mid_rst_rx_valid", rx_valid, 0);
    check("mid_rst_rx_data", rx_data, 8'h00);
    reset_n = 1'b1;
    cs_release();

`ifdef SIRV_SPI_SLAVE_ENDIAN_EN
    // LSB-first transfer
    rx_base = rx_cnt;
    lsb_first = 1'b1;
    push_tx(8'h01);
    cs_assert();
    check("lsb_first_miso_bit", miso, 1);
    spi_xfer(8, 8'h80, 1'b1, got);
    check("lsb_miso_word", got, 8'h01);
    cs_release();
    check("lsb_rx_cnt", rx_cnt - rx_base, 1);
    check("lsb_rx_data", rx_data, 8'h80);
    lsb_first = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
